delay_line_ctrl: RTL and testbench
==================================

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Parameters
REQ-001 SHALL provide DEPTH, default 10, number of stages in the attached shift register.
REQ-002 SHALL provide DW, default 8, sample width.

Interface
REQ-003 SHALL have clk  input  1  sole clock, rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1  and in_ready  output  1  as the upstream sample handshake.
REQ-006 SHALL have in_data  input  DW  upstream sample.
REQ-007 SHALL have in_eol  input  1  marking the last sample of a line; qualified by in_valid && in_ready.
REQ-008 SHALL have out_valid  output  1  and out_ready  input  1  as the downstream handshake.
REQ-009 SHALL have out_data  output  DW  delayed sample, equal to sr_q.
REQ-010 SHALL have out_last  output  1  marking the final output beat of a line.
REQ-011 SHALL have sr_ce  output  1,  sr_sclr  output  1,  sr_d  output  DW  driving the shift register, and sr_q  input  DW  from its last stage.
REQ-012 SHALL have line_cnt  output  16  for completed lines, and busy  output  1.

Function
REQ-013 SHALL implement the states CLEAR, FILL, RUN, PAD and FLUSH, plus a fill counter (0..DEPTH), a pad counter and a remaining counter.
REQ-014 CLEAR SHALL last 1 cycle with sr_sclr=1, sr_ce=0, in_ready=0 and out_valid=0, then go to FILL with fill=0.
REQ-015 FILL SHALL behave as follows.
- in_ready=1, out_valid=0.
- On transfer: sr_ce=1, sr_d=in_data, fill+1.
- Without in_eol: go to RUN when fill+1==DEPTH.
- With in_eol: go to PAD with pad=DEPTH-(fill+1); if that is 0, go directly to FLUSH with remaining=DEPTH.
REQ-016 RUN SHALL behave as follows.
- in_ready=out_ready; out_valid=in_valid; out_data=sr_q; sr_d=in_data.
- sr_ce=in_valid && out_ready, so each input transfer pops exactly one output beat.
- A transfer with in_eol goes to FLUSH with remaining=DEPTH.
REQ-017 PAD SHALL behave as follows.
- sr_ce=1, sr_d=0, in_ready=0, out_valid=0; pad decrements every cycle.
- When pad reaches 0, go to FLUSH with remaining=fill.
REQ-018 FLUSH SHALL behave as follows.
- out_valid=1, out_data=sr_q, sr_d=0, sr_ce=out_ready, in_ready=0; remaining decrements per accepted beat.
- out_last=1 when remaining==1.
- After the last beat: line_cnt+1, then go to CLEAR.
REQ-019 Every line SHALL yield exactly as many output beats as input samples, in input order, with zero samples never emitted.
REQ-020 sr_ce SHALL never be asserted in the same cycle as sr_sclr.
REQ-021 While out_valid=1 and out_ready=0, sr_ce SHALL be 0 and out_data SHALL hold stable.
REQ-022 line_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-023 busy SHALL be 1 in RUN, PAD and FLUSH, and in FILL when fill>0; otherwise 0.
REQ-024 out_last SHALL be 0 outside FLUSH.

Reset
REQ-025 While rst_n=0, the block SHALL hold the following outputs:
- state=CLEAR; all counters 0; line_cnt=0.
- in_ready=0, out_valid=0, out_last=0, sr_ce=0, busy=0.
- sr_sclr=1.
REQ-026 Reset asserted in any state SHALL abort the line immediately; after release, the first cycle SHALL be the CLEAR pulse.

Verification (DEPTH=10)
REQ-027 Release rst_n -> exactly one cycle of sr_sclr=1, then in_ready=1 the following cycle.
REQ-028 Line 1..12 with in_eol on 12 and out_ready=1:
- No out_valid while 1..10 are accepted.
- out_data=1 with the 11th transfer, then 2..12.
- out_last with 12; line_cnt=1.
REQ-029 Line 5,6,7 with in_eol on 7 -> 7 PAD cycles with sr_ce=1 and sr_d=0 -> beats 5,6,7, out_last on 7, then CLEAR.
REQ-030 In RUN, drop out_ready for 4 cycles -> in_ready=0, sr_ce=0 and out_data constant throughout; the sequence resumes without loss or duplication.
REQ-031 in_eol on the 10th sample -> no PAD cycles; exactly 10 FLUSH beats, out_last on the 10th.
REQ-032 Assert rst_n=0 mid-FLUSH -> outputs take reset values asynchronously and line_cnt=0; the next line is produced correctly from the CLEAR pulse.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// Controller for an external DEPTH-stage shift register used as a line delay.
// Each line is primed into the register and then streamed out one beat per
// input sample. Short lines are padded with zeros so their samples reach the
// last stage. The line's tail is then flushed, so every input sample comes out
// exactly once.
module delay_line_ctrl #(
   parameter int DEPTH = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_eol,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          sr_ce,
   output logic          sr_sclr,
   output logic [DW-1:0] sr_d,
   input  logic [DW-1:0] sr_q,
   output logic [15:0]   line_cnt,
   output logic          busy
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [2:0] {S_CLEAR, S_FILL, S_RUN, S_PAD, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] fill_q, fill_d;
   logic [CW-1:0] pad_q, pad_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [15:0]   line_q, line_d;
   logic [CW-1:0] fill_inc;

   assign fill_inc = fill_q + ONE_C;
   assign out_data = sr_q;
   assign line_cnt = line_q;

   // Next-state, counter updates and handshake/shift-register controls per state
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      pad_d     = pad_q;
      rem_d     = rem_q;
      line_d    = line_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      sr_ce     = 1'b0;
      sr_sclr   = 1'b0;
      sr_d      = '0;
      busy      = 1'b0;
      case (state_q)
         S_CLEAR: begin
            sr_sclr = 1'b1;
            fill_d  = '0;
            pad_d   = '0;
            rem_d   = '0;
            state_d = S_FILL;
         end
         S_FILL: begin
            in_ready = 1'b1;
            busy     = (fill_q != '0);
            sr_d     = in_data;
            if (in_valid) begin
               sr_ce  = 1'b1;
               fill_d = fill_inc;
               if (in_eol) begin
                  // A line that exactly fills the register needs no padding
                  if (fill_inc == DEPTH_C) begin
                     state_d = S_FLUSH;
                     rem_d   = DEPTH_C;
                  end else begin
                     state_d = S_PAD;
                     pad_d   = DEPTH_C - fill_inc;
                  end
               end else if (fill_inc == DEPTH_C) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            in_ready  = out_ready;
            out_valid = in_valid;
            sr_d      = in_data;
            sr_ce     = in_valid && out_ready;
            if (in_valid && out_ready && in_eol) begin
               state_d = S_FLUSH;
               rem_d   = DEPTH_C;
            end
         end
         S_PAD: begin
            busy  = 1'b1;
            sr_ce = 1'b1;
            pad_d = pad_q - ONE_C;
            if (pad_q == ONE_C) begin
               state_d = S_FLUSH;
               rem_d   = fill_q;
            end
         end
         S_FLUSH: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            sr_ce     = out_ready;
            out_last  = (rem_q == ONE_C);
            if (out_ready) begin
               rem_d = rem_q - ONE_C;
               if (rem_q == ONE_C) begin
                  line_d  = line_q + 16'd1;
                  state_d = S_CLEAR;
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // State and counter registers; reset aborts any line and restarts at CLEAR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLEAR;
         fill_q  <= '0;
         pad_q   <= '0;
         rem_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         pad_q   <= pad_d;
         rem_q   <= rem_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: models the attached shift register and checks
// the output stream against a queue of accepted input samples.
module tb_delay_line_ctrl;

   localparam int DEPTH = 10;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_eol;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic          sr_ce, sr_sclr;
   logic [DW-1:0] sr_d, sr_q;
   logic [15:0]   line_cnt;
   logic          busy;

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] sr[DEPTH];
   int            n_cmp = 0;
   int            n_err = 0;
   int            beats = 0;
   int            padcnt = 0;

   always #5 clk = ~clk;

   delay_line_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eol(in_eol),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .sr_ce(sr_ce), .sr_sclr(sr_sclr), .sr_d(sr_d), .sr_q(sr_q),
      .line_cnt(line_cnt), .busy(busy)
   );

   // Attached shift register
   always @(posedge clk) begin
      if (sr_sclr) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (sr_ce) begin
         sr[0] <= sr_d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   assign sr_q = sr[DEPTH-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: push on input transfer, pop and compare on output beat
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         chk("ce_with_sclr", 32'(sr_ce & sr_sclr), 32'd0);
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("extra_beat", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
            beats++;
         end else if (!out_valid) begin
            chk("last_idle", 32'(out_last), 32'd0);
         end
         if (sr_ce && !out_valid && !in_ready) begin
            padcnt++;
            chk("pad_zero", 32'(sr_d), 32'd0);
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e.d    = in_data;
            e.last = in_eol;
            sbq.push_back(e);
         end
      end
   end

   // Drive one line of n samples base, base+1, ...; optional 4-cycle output stall
   task automatic send_line(input int n, input int base, input int stall_at);
      logic [DW-1:0] held;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         int t;
         in_valid = 1'b1;
         in_data  = 8'(base + i);
         in_eol   = (i == n - 1);
         if (i == stall_at) begin
            out_ready = 1'b0;
            held = '0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (k == 0) held = out_data;
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_sr_ce", 32'(sr_ce), 32'd0);
               chk("stall_data", 32'(out_data), 32'(held));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!(in_valid && in_ready) && t < 50);
         if (t >= 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
         chk("out_valid_at_accept", 32'(out_valid), 32'(i >= DEPTH));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_eol   = 1'b0;
   endtask

   task automatic wait_done(input int lines);
      int t = 0;
      while (!(line_cnt == 16'(lines) && sbq.size() == 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("line_done_in_time", 32'(t < 300), 32'd1);
      chk("line_cnt", 32'(line_cnt), 32'(lines));
      chk("busy_after_line", 32'(busy), 32'd0);
   endtask

   initial begin
      int t;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_eol = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_sr_ce", 32'(sr_ce), 32'd0);
      chk("rst_sr_sclr", 32'(sr_sclr), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_line_cnt", 32'(line_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("clear_sclr", 32'(sr_sclr), 32'd1);
      chk("clear_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("fill_sclr", 32'(sr_sclr), 32'd0);
      chk("fill_in_ready", 32'(in_ready), 32'd1);

      // Long line through RUN
      beats = 0; padcnt = 0;
      send_line(12, 1, -1);
      wait_done(1);
      chk("beats_long", 32'(beats), 32'd12);
      chk("pad_long", 32'(padcnt), 32'd0);

      // Short line padded with zeros
      beats = 0; padcnt = 0;
      send_line(3, 5, -1);
      wait_done(2);
      chk("beats_short", 32'(beats), 32'd3);
      chk("pad_short", 32'(padcnt), 32'd7);

      // Output backpressure in RUN
      beats = 0; padcnt = 0;
      send_line(15, 20, 12);
      wait_done(3);
      chk("beats_stall", 32'(beats), 32'd15);

      // Line of exactly DEPTH samples
      beats = 0; padcnt = 0;
      send_line(10, 40, -1);
      wait_done(4);
      chk("beats_exact", 32'(beats), 32'd10);
      chk("pad_exact", 32'(padcnt), 32'd0);

      // Reset in the middle of FLUSH
      out_ready = 1'b0;
      send_line(3, 60, -1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("reach_flush", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_sr_sclr", 32'(sr_sclr), 32'd1);
      chk("arst_sr_ce", 32'(sr_ce), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_line_cnt", 32'(line_cnt), 32'd0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rerun_clear", 32'(sr_sclr), 32'd1);
      beats = 0; padcnt = 0;
      send_line(4, 70, -1);
      wait_done(1);
      chk("beats_after_rst", 32'(beats), 32'd4);
      chk("pad_after_rst", 32'(padcnt), 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
